// File: rtl/mem_loader_pkg.sv
// Shared types and defaults for the UART frame loader.
// State encoding, error codes and default framing constants.
package mem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT,
        S_ADDR,
        S_DHI,
        S_DLO,
        S_CRC,
        S_COMMIT
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_CNT  = 2'b01;
    localparam logic [1:0] ERR_CRC  = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
    localparam logic [7:0] DEF_CRC_POLY  = 8'h07;

endpackage

// File: rtl/crc8_step.sv
// One-byte CRC-8 update, MSB first, no reflection.
// Purely combinational; caller owns the running register.
module crc8_step (
    input  logic [7:0] crc_in,
    input  logic [7:0] data,
    input  logic [7:0] poly,
    output logic [7:0] crc_out
);

    logic [7:0] c;

    always_comb begin
        c = crc_in ^ data;
        for (int k = 0; k < 8; k++) begin
            if (c[7]) c = {c[6:0], 1'b0} ^ poly;
            else      c = {c[6:0], 1'b0};
        end
        crc_out = c;
    end

endmodule

// File: rtl/uart_mem_loader.sv
// Parses CRC-protected UART frames into a local buffer, then
// stalls the CPU and bursts the words into data memory.
module uart_mem_loader
    import mem_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE   = DEF_SYNC_BYTE,
    parameter logic [7:0] CRC_POLY    = DEF_CRC_POLY,
    parameter int         TIMEOUT_CYC = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        mem_we,
    output logic [3:0]  mem_addr,
    output logic [15:0] mem_wdata,
    output logic        cpu_stall,
    output logic        load_done,
    output logic        load_err,
    output logic [1:0]  err_code
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    state_t      state;
    state_t      state_n;
    logic [7:0]  crc;
    logic [7:0]  crc_nxt;
    logic [4:0]  cnt;
    logic [4:0]  cnt_m1;
    logic [3:0]  last_idx;
    logic [3:0]  base;
    logic [3:0]  idx;
    logic [7:0]  hi;
    logic [TW-1:0] timer;
    logic [15:0] buffer [16];

    logic        in_frame;
    logic        tmo;
    logic        err_set;
    logic [1:0]  err_val;
    logic        done_set;
    logic        sync_hit;

    crc8_step u_crc (
        .crc_in  (crc),
        .data    (rx_data),
        .poly    (CRC_POLY),
        .crc_out (crc_nxt)
    );

    assign cnt_m1   = cnt - 5'd1;
    assign last_idx = cnt_m1[3:0];
    assign sync_hit = rx_valid && (rx_data == SYNC_BYTE);

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n  = state;
        err_set  = 1'b0;
        err_val  = ERR_NONE;
        done_set = 1'b0;
        in_frame = (state != S_IDLE) && (state != S_COMMIT);
        tmo      = in_frame && !rx_valid && (timer == TMO_LAST);
        unique case (state)
            S_IDLE: begin
                if (sync_hit) state_n = S_CNT;
            end
            S_CNT: begin
                if (rx_valid) begin
                    if (rx_data == 8'd0 || rx_data > 8'd16) begin
                        state_n = S_IDLE;
                        err_set = 1'b1;
                        err_val = ERR_CNT;
                    end else begin
                        state_n = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (rx_valid) begin
                    if (rx_data[7:4] != 4'd0) begin
                        state_n = S_IDLE;
                        err_set = 1'b1;
                        err_val = ERR_CNT;
                    end else begin
                        state_n = S_DHI;
                    end
                end
            end
            S_DHI: begin
                if (rx_valid) state_n = S_DLO;
            end
            S_DLO: begin
                if (rx_valid) begin
                    if (idx == last_idx) state_n = S_CRC;
                    else                 state_n = S_DHI;
                end
            end
            S_CRC: begin
                if (rx_valid) begin
                    if (rx_data == crc) begin
                        state_n = S_COMMIT;
                    end else begin
                        state_n = S_IDLE;
                        err_set = 1'b1;
                        err_val = ERR_CRC;
                    end
                end
            end
            S_COMMIT: begin
                if (idx == last_idx) begin
                    state_n  = S_IDLE;
                    done_set = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (tmo) begin
            state_n = S_IDLE;
            err_set = 1'b1;
            err_val = ERR_TMO;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            crc       <= 8'd0;
            cnt       <= 5'd0;
            base      <= 4'd0;
            idx       <= 4'd0;
            hi        <= 8'd0;
            timer     <= '0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            load_done <= done_set;
            load_err  <= err_set;
            if (err_set)       err_code <= err_val;
            else if (done_set) err_code <= ERR_NONE;

            // Idle gap measured only while a frame is open
            if (rx_valid || !in_frame || err_set) timer <= '0;
            else                                  timer <= timer + 1'b1;

            unique case (state)
                S_IDLE: begin
                    if (sync_hit) begin
                        crc <= 8'd0;
                        idx <= 4'd0;
                    end
                end
                S_CNT: begin
                    if (rx_valid) begin
                        cnt <= rx_data[4:0];
                        crc <= crc_nxt;
                    end
                end
                S_ADDR: begin
                    if (rx_valid) begin
                        base <= rx_data[3:0];
                        crc  <= crc_nxt;
                    end
                end
                S_DHI: begin
                    if (rx_valid) begin
                        hi  <= rx_data;
                        crc <= crc_nxt;
                    end
                end
                S_DLO: begin
                    if (rx_valid) begin
                        crc <= crc_nxt;
                        if (idx == last_idx) idx <= 4'd0;
                        else                 idx <= idx + 4'd1;
                    end
                end
                S_COMMIT: idx <= idx + 4'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_DLO && rx_valid) buffer[idx] <= {hi, rx_data};
    end

    // Loader owns the memory port only while committing
    always_comb begin
        if (state == S_COMMIT) begin
            mem_we    = 1'b1;
            mem_addr  = base + idx;
            mem_wdata = buffer[idx];
            cpu_stall = 1'b1;
        end else begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            cpu_stall = 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Randomized frame-level bench for uart_mem_loader with a
// cycle-indexed expectation schedule and per-cycle compare.
module tb_uart_mem_loader;
    import mem_loader_pkg::*;

    localparam int         TMO  = 1000;
    localparam logic [7:0] SYNC = 8'hA5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        cpu_we;
    logic [3:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic        mem_we;
    logic [3:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_stall;
    logic        load_done;
    logic        load_err;
    logic [1:0]  err_code;

    uart_mem_loader #(
        .SYNC_BYTE   (SYNC),
        .CRC_POLY    (8'h07),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_stall (cpu_stall),
        .load_done (load_done),
        .load_err  (load_err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    logic [3:0]  exp_wa   [int];
    logic [15:0] exp_wd   [int];
    bit          exp_done [int];
    logic [1:0]  exp_err  [int];
    bit          rst_mark [int];
    logic [1:0]  exp_code = 2'b00;
    logic [15:0] wbuf [16];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h",
                     name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (rst_mark.exists(cyc)) exp_code = ERR_NONE;
            if (exp_err.exists(cyc))  exp_code = exp_err[cyc];
            if (exp_done.exists(cyc)) exp_code = ERR_NONE;
            if (exp_wa.exists(cyc)) begin
                check("commit_we", 32'(mem_we), 32'(1));
                check("commit_addr", 32'(mem_addr), 32'(exp_wa[cyc]));
                check("commit_data", 32'(mem_wdata), 32'(exp_wd[cyc]));
                check("commit_stall", 32'(cpu_stall), 32'(1));
            end else begin
                check("pass_we", 32'(mem_we), 32'(cpu_we));
                check("pass_addr", 32'(mem_addr), 32'(cpu_addr));
                check("pass_data", 32'(mem_wdata), 32'(cpu_wdata));
                check("pass_stall", 32'(cpu_stall), 32'(0));
            end
            check("load_done", 32'(load_done),
                  32'(exp_done.exists(cyc)));
            check("load_err", 32'(load_err),
                  32'(exp_err.exists(cyc)));
            check("err_code", 32'(err_code), 32'(exp_code));
        end
    end

    // CPU model: holds its store while stalled
    initial begin
        cpu_we    = 1'b0;
        cpu_addr  = 4'd0;
        cpu_wdata = 16'd0;
        forever begin
            @(posedge clk);
            #1;
            if (!cpu_stall) begin
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = 4'($urandom);
                cpu_wdata = 16'($urandom);
            end
        end
    end

    function automatic logic [7:0] crc_model(input logic [7:0] q[$]);
        logic [7:0] c;
        bit fb;
        c = 8'd0;
        foreach (q[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[7] ^ q[i][b];
                c  = {c[6:0], 1'b0};
                if (fb) c = c ^ 8'h07;
            end
        end
        return c;
    endfunction

    function automatic logic [7:0] noise_byte();
        logic [7:0] v;
        do v = 8'($urandom); while (v == SYNC);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b, output int e);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        e        = cyc;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    // Frame-level predictor: decide the outcome, send, schedule
    task automatic send_frame(input logic [7:0] cnt,
                              input logic [7:0] adr,
                              input logic [7:0] crc_xor,
                              input int trunc, input int maxgap,
                              input int rst_at, input bit noise,
                              output int ec);
        logic [7:0] body[$];
        logic [7:0] fr[$];
        int n, last, e, e2, errc, k_end;
        n = int'(cnt);
        body.push_back(cnt);
        body.push_back(adr);
        if (cnt >= 8'd1 && cnt <= 8'd16) begin
            for (int k = 0; k < n; k++) begin
                body.push_back(wbuf[k][15:8]);
                body.push_back(wbuf[k][7:0]);
            end
        end
        fr.push_back(SYNC);
        foreach (body[i]) fr.push_back(body[i]);
        fr.push_back(crc_model(body) ^ crc_xor);
        if (cnt == 8'd0 || cnt > 8'd16) begin
            last = 1;
            errc = 1;
        end else if (adr[7:4] != 4'd0) begin
            last = 2;
            errc = 1;
        end else begin
            last = fr.size() - 1;
            errc = (crc_xor != 8'd0) ? 2 : 0;
        end
        if (trunc >= 0 && trunc < last) begin
            last = trunc;
            errc = 3;
        end
        e  = 0;
        ec = -1;
        for (int i = 0; i <= last; i++) begin
            if (i > 0) idle(int'($urandom_range(0, maxgap)));
            send_byte(fr[i], e);
        end
        if (errc == 3) begin
            exp_err[e + TMO] = ERR_TMO;
            idle(TMO);
        end else if (errc != 0) begin
            exp_err[e] = 2'(errc);
        end else begin
            ec    = e;
            k_end = (rst_at >= 0) ? rst_at : n;
            for (int k = 0; k < k_end; k++) begin
                exp_wa[e + k] = adr[3:0] + 4'(k);
                exp_wd[e + k] = wbuf[k];
            end
            if (rst_at < 0) begin
                exp_done[e + n] = 1'b1;
                if (noise) begin
                    send_byte(noise_byte(), e2);
                    idle(n - 1);
                end else begin
                    idle(n);
                end
            end else begin
                idle(rst_at - 1);
                reset = 1'b0;
                tick();
                rst_mark[cyc] = 1'b1;
                tick();
                rst_mark[cyc] = 1'b1;
                reset = 1'b1;
                tick();
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pq[$];
        logic [7:0] c, a, x;
        int e, d, kind, n, tr, rs, tmo_cnt;
        bit nz;

        rx_valid = 1'b0;
        rx_data  = 8'd0;
        tmo_cnt  = 0;
        tick();
        chk_en = 1'b1;
        idle(2);
        reset = 1'b1;
        idle(2);

        pq = {8'h01, 8'h03, 8'h12, 8'h34};
        check("pin_crc_a", 32'(crc_model(pq)), 32'h5A);

        wbuf[0] = 16'h1234;
        send_frame(8'h01, 8'h03, 8'h00, -1, 0, -1, 1'b0, e);
        check("pin_a_addr", 32'(exp_wa[e]), 32'h3);
        check("pin_a_data", 32'(exp_wd[e]), 32'h1234);
        check("pin_a_done", 32'(exp_done.exists(e + 1)), 32'(1));
        idle(3);

        send_frame(8'h01, 8'h03, 8'h01, -1, 0, -1, 1'b0, e);
        check("pin_bad_crc", 32'(e), 32'hFFFF_FFFF);
        idle(2);

        wbuf[0] = 16'hAAAA;
        wbuf[1] = 16'h5555;
        send_frame(8'h02, 8'h0F, 8'h00, -1, 0, -1, 1'b0, e);
        check("pin_wrap_a0", 32'(exp_wa[e]), 32'hF);
        check("pin_wrap_a1", 32'(exp_wa[e + 1]), 32'h0);
        check("pin_wrap_d1", 32'(exp_wd[e + 1]), 32'h5555);

        send_frame(8'h00, 8'h03, 8'h00, -1, 0, -1, 1'b0, e);
        send_frame(8'h11, 8'h03, 8'h00, -1, 0, -1, 1'b0, e);
        send_frame(8'h01, 8'h10, 8'h00, -1, 0, -1, 1'b0, e);
        wbuf[0] = 16'hBEEF;
        send_frame(8'h01, 8'h07, 8'h00, -1, 1, -1, 1'b0, e);

        send_frame(8'h01, 8'h03, 8'h00, 2, 0, -1, 1'b0, e);
        idle(2);

        for (int k = 0; k < 16; k++) wbuf[k] = 16'($urandom);
        send_frame(8'h10, 8'h05, 8'h00, -1, 0, -1, 1'b1, e);
        idle(2);

        for (int k = 0; k < 16; k++) wbuf[k] = 16'($urandom);
        send_frame(8'h10, 8'h09, 8'h00, -1, 0, 2, 1'b0, e);
        check("pin_rst_w1", 32'(exp_wa.exists(e + 1)), 32'(1));
        check("pin_rst_w2", 32'(exp_wa.exists(e + 2)), 32'(0));
        check("pin_rst_done", 32'(exp_done.exists(e + 16)), 32'(0));
        idle(2);

        for (int f = 0; f < 60; f++) begin
            for (int k = 0; k < 16; k++) wbuf[k] = 16'($urandom);
            kind = int'($urandom_range(0, 11));
            n    = int'($urandom_range(1, 16));
            c    = 8'(n);
            a    = {4'h0, 4'($urandom)};
            x    = 8'h00;
            tr   = -1;
            rs   = -1;
            nz   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) send_byte(noise_byte(), d);
            case (kind)
                0: c = ($urandom_range(0, 1) == 1) ? 8'h00
                       : 8'($urandom_range(17, 255));
                1: a[7:4] = 4'($urandom_range(1, 15));
                2: x = 8'(1 << $urandom_range(0, 7));
                3: if (tmo_cnt < 3) begin
                    tr = int'($urandom_range(0, 2 * n + 2));
                    tmo_cnt++;
                end
                4: rs = int'($urandom_range(1, n));
                default: ;
            endcase
            send_frame(c, a, x, tr, 3, rs, nz, e);
        end

        idle(5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
